// File: rtl/demux_framer.sv
// Serial-to-parallel framer: collects 8 lanes of LANE_W bits into a registered frame.
// Optional DEMUX_DIRECT_EN adds a direct lane-write path into the output register.
module demux_framer #(
    parameter int LANE_W = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LANE_W-1:0]   in,
    input  logic                in_valid,
    input  logic                frame_start,
`ifdef DEMUX_DIRECT_EN
    input  logic                dir_we,
    input  logic [2:0]          sel,
`endif
    output logic [8*LANE_W-1:0] out,
    output logic                out_valid,
    output logic                busy,
    output logic                err
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    logic [0:0]          state;
    logic [2:0]          idx;
    logic [8*LANE_W-1:0] shadow;

    logic                accept;
    logic                start_beat;
    logic                data_beat;
    logic                complete;
    logic                restart;
    logic [8*LANE_W-1:0] frame_next;
    logic [8*LANE_W-1:0] out_next;

    always_comb begin
`ifdef DEMUX_DIRECT_EN
        accept = in_valid & ~dir_we;
`else
        accept = in_valid;
`endif
        start_beat = accept & frame_start;
        data_beat  = accept & ~frame_start & (state == COLLECT);
        complete   = data_beat & (idx == 3'd7);
        restart    = start_beat & (state == COLLECT);

        frame_next = shadow;
        frame_next[7*LANE_W +: LANE_W] = in;

        out_next = complete ? frame_next : out;
`ifdef DEMUX_DIRECT_EN
        // Applied after the frame merge so lane sel always wins a same-edge completion.
        if (dir_we) begin
            out_next[int'(sel)*LANE_W +: LANE_W] = in;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            shadow    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            out       <= out_next;
            out_valid <= complete;
            err       <= restart;
            if (start_beat) begin
                shadow[LANE_W-1:0] <= in;
                idx                <= 3'd1;
                state              <= COLLECT;
            end else if (data_beat) begin
                shadow[int'(idx)*LANE_W +: LANE_W] <= in;
                idx <= idx + 3'd1;
                if (complete) begin
                    state <= IDLE;
                end
            end
        end
    end

    assign busy = (state == COLLECT);

endmodule

// File: tb/tb_demux_framer.sv
// Randomized scoreboard bench for demux_framer (LANE_W=1) with a queue-based lane model.
module tb_demux_framer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in;
    logic       in_valid;
    logic       frame_start;
    logic [7:0] out;
    logic       out_valid;
    logic       busy;
    logic       err;
`ifdef DEMUX_DIRECT_EN
    logic       dir_we;
    logic [2:0] sel;
`endif

    demux_framer #(.LANE_W(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (in),
        .in_valid    (in_valid),
        .frame_start (frame_start),
`ifdef DEMUX_DIRECT_EN
        .dir_we      (dir_we),
        .sel         (sel),
`endif
        .out         (out),
        .out_valid   (out_valid),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         passes = 0;
    bit         running = 1'b0;

    // Reference model: lanes gathered so far, last delivered frame, pending frames.
    bit         coll[$];
    logic [7:0] m_out = 8'h00;
    bit         m_ov = 1'b0;
    bit         m_err = 1'b0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        logic [7:0] f;
        m_ov  = 1'b0;
        m_err = 1'b0;
        if (!rst_n) begin
            coll.delete();
            m_out = 8'h00;
            return;
        end
`ifdef DEMUX_DIRECT_EN
        if (dir_we) begin
            m_out[sel] = in;
            return;
        end
`endif
        if (!in_valid) return;
        if (frame_start) begin
            if (coll.size() > 0) m_err = 1'b1;
            coll.delete();
            coll.push_back(in);
        end else if (coll.size() > 0) begin
            coll.push_back(in);
            if (coll.size() == 8) begin
                for (int i = 0; i < 8; i++) f[i] = coll[i];
                m_out = f;
                m_ov  = 1'b1;
                exp_q.push_back(f);
                coll.delete();
            end
        end
    endtask

    task automatic cycle(input bit r, input bit v, input bit fs, input bit d);
        @(negedge clk);
        rst_n       = r;
        in_valid    = v;
        frame_start = fs;
        in          = d;
`ifdef DEMUX_DIRECT_EN
        dir_we      = 1'b0;
        sel         = 3'd0;
`endif
        if (!r) begin
            #1;
            chk("rst_out", out, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err", err, 0);
            chk("rst_out_valid", out_valid, 0);
        end
        @(posedge clk);
        model_step();
    endtask

`ifdef DEMUX_DIRECT_EN
    task automatic dcycle(input bit v, input bit fs, input bit d, input logic [2:0] s);
        @(negedge clk);
        rst_n       = 1'b1;
        in_valid    = v;
        frame_start = fs;
        in          = d;
        dir_we      = 1'b1;
        sel         = s;
        @(posedge clk);
        model_step();
    endtask
`endif

    task automatic send_frame(input logic [7:0] f, input int gap);
        for (int i = 0; i < 8; i++) begin
            repeat (gap) cycle(1'b1, 1'b0, 1'b0, 1'($urandom));
            cycle(1'b1, 1'b1, (i == 0), f[i]);
        end
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, (i == 0), 1'($urandom));
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle compare status against the model; on out_valid pop the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (running) begin
                chk("busy", busy, (coll.size() > 0));
                chk("err", err, m_err);
                chk("out_valid", out_valid, m_ov);
                chk("out_hold", out, m_out);
                if (out_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL sb_frame: got unexpected frame %0h expected no frame at %0t", out, $time);
                    end else begin
                        chk("sb_frame", out, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish within 1ms");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in = 1'b0; in_valid = 1'b0; frame_start = 1'b0;
`ifdef DEMUX_DIRECT_EN
        dir_we = 1'b0; sel = 3'd0;
`endif
        #1;
        chk("por_out", out, 0);
        chk("por_busy", busy, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        running = 1'b1;
        idle(2);

        send_frame(8'h55, 0);
        idle(2);
        chk("frame_55", out, 8'h55);

        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h55, 3);
        idle(2);
        chk("gap_frame_55", out, 8'h55);

        send_partial(4);
        send_frame(8'hF0, 0);
        idle(2);
        chk("restart_f0", out, 8'hF0);

        send_partial(5);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        send_frame(8'hA5, 0);
        idle(1);
        chk("post_rst_a5", out, 8'hA5);

        repeat (4) cycle(1'b1, 1'b1, 1'b0, 1'($urandom));
        send_frame(8'h3C, 1);
        idle(1);
        chk("stray_3c", out, 8'h3C);

        send_frame(8'h12, 0);
        send_frame(8'h34, 0);
        idle(1);
        chk("b2b_34", out, 8'h34);

`ifdef DEMUX_DIRECT_EN
        send_frame(8'h55, 0);
        dcycle(1'b0, 1'b0, 1'b1, 3'd7);
        idle(1);
        chk("dir_d5", out, 8'hD5);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, (i == 0), 1'b1);
        dcycle(1'b1, 1'b0, 1'b0, 3'd2);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("dir_collision", out, 8'h7F);
`endif

        for (int n = 0; n < 3000; n++) begin
`ifdef DEMUX_DIRECT_EN
            if ($urandom_range(0, 19) == 0) begin
                dcycle(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
                continue;
            end
`endif
            cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 7) == 0), 1'($urandom));
        end
        idle(2);
        running = 1'b0;
        chk("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/demux_framer.md
DEMUX_FRAMER -- requirements
Module: demux_framer

Interface
REQ-001 SHALL have parameter: LANE_W, default 1, width in bits of each of the 8 lanes.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: in  input  LANE_W  serial lane data, one lane per accepted beat.
REQ-005 SHALL have port: in_valid  input  1  beat qualifier for in.
REQ-006 SHALL have port: frame_start  input  1  marks the current beat as lane 0 of a new frame; ignored unless in_valid=1.
REQ-007 SHALL have port: out  output  8*LANE_W  registered parallel frame; lane i occupies bits [i*LANE_W +: LANE_W].
REQ-008 SHALL have port: out_valid  output  1  one-cycle pulse when out has been updated with a complete frame.
REQ-009 SHALL have port: busy  output  1  high while a frame is partially collected.
REQ-010 SHALL have port: err  output  1  one-cycle pulse when a partial frame is discarded.
REQ-011 SHALL have ports, present only with DEMUX_DIRECT_EN: dir_we  input  1  direct write strobe; sel  input  3  target lane for the direct write.

Function
REQ-012 SHALL implement FSM states IDLE and COLLECT, plus a 3-bit lane counter idx and an 8-lane shadow buffer.
REQ-013 In IDLE: in_valid=1 with frame_start=1 SHALL write in to shadow lane 0, set idx=1, and move to COLLECT.
REQ-014 In IDLE: in_valid=1 with frame_start=0 SHALL drop the beat, leaving state and outputs unchanged and err low.
REQ-015 In COLLECT: in_valid=1 with frame_start=0 SHALL write in to shadow lane idx and increment idx.
REQ-016 In COLLECT: in_valid=0 SHALL hold all state; gaps between beats are unbounded.
REQ-017 On the beat where idx=7: out SHALL load all 8 lanes atomically, with lane 7 taken from in on that beat; out_valid SHALL be 1 in the following cycle; idx SHALL wrap to 0; FSM SHALL return to IDLE.
REQ-018 Latency: out and out_valid SHALL update on the clock edge that samples the 8th beat, and out_valid SHALL fall after exactly one cycle.
REQ-019 In COLLECT: in_valid=1 with frame_start=1 SHALL discard the partial frame, pulse err for one cycle, write in to lane 0, and set idx=1 (restart).
REQ-020 out SHALL hold its last complete frame until the next completion; a partial or aborted frame SHALL never modify out.
REQ-021 busy SHALL equal 1 exactly when the FSM is in COLLECT.
REQ-022 Back-to-back frames SHALL be supported: frame_start on the beat immediately after a completion SHALL be accepted with no idle cycle.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, idx=0, shadow=0, out=0, out_valid=0, busy=0, err=0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame without asserting err.
REQ-025 After rst_n deasserts, the first accepted beat SHALL be on the first rising edge at which rst_n=1.

Configuration
REQ-026 Macro DEMUX_DIRECT_EN SHALL control the direct-write feature.
REQ-027 With DEMUX_DIRECT_EN defined: dir_we=1 SHALL write in directly into out lane sel on that edge, with no out_valid pulse and no change to FSM, idx, or shadow.
REQ-028 With DEMUX_DIRECT_EN defined: if a direct write and a frame completion occur on the same edge, the direct write SHALL win for lane sel, and the other lanes SHALL take the frame data.
REQ-029 With DEMUX_DIRECT_EN defined: dir_we=1 SHALL take priority over in_valid for the in bus; that beat SHALL not be collected.
REQ-030 Without DEMUX_DIRECT_EN: dir_we and sel SHALL not exist, and behaviour SHALL be exactly as in REQ-012 to REQ-025.

Verification (LANE_W=1)
REQ-031 SHALL cover: frame_start on beat 0, then bits 1,0,1,0,1,0,1,0 on lanes 0..7, consecutive -> out=8'h55 with out_valid high one cycle; busy high beats 1..7.
REQ-032 SHALL cover: the same frame with 3-cycle in_valid gaps between beats -> identical out=8'h55, a single out_valid pulse, and out unchanged (0) until completion.
REQ-033 SHALL cover: 4 beats, then frame_start with a new 8'hF0 frame -> err pulse on the restart, out=8'hF0, and no intermediate out update.
REQ-034 SHALL cover: rst_n low after 5 beats of a frame -> out=0, busy=0, err stays 0; a following full frame 8'hA5 is collected correctly.
REQ-035 SHALL cover: beats with frame_start=0 in IDLE, followed by a valid 8'h3C frame -> the stray beats are ignored and out=8'h3C.
REQ-036 SHALL cover, with DEMUX_DIRECT_EN: out=8'h55 after a frame; dir_we with sel=7 and in=1 -> out=8'hD5 with no out_valid pulse; a same-edge collision then follows REQ-028.
